// File: rtl/smith_waterman_pe.sv
// One Smith-Waterman processing element with affine gaps: holds a read base,
// computes one H cell per cycle and forwards V/F/T/init downstream.
module smith_waterman_pe #(
   parameter int MATCH      = 10,
   parameter int MISMATCH   = -2,
   parameter int GAP_OPEN   = -2,
   parameter int GAP_EXTEND = -1,
   parameter int WIDTH      = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [WIDTH-1:0] V_in,
   input  logic signed [WIDTH-1:0] F_in,
   input  logic [1:0]              T_in,
   input  logic [1:0]              S_in,
   input  logic                    store_S,
   input  logic                    init_in,
   output logic signed [WIDTH-1:0] V_out,
   output logic signed [WIDTH-1:0] F_out,
   output logic [1:0]              T_out,
   output logic                    init_out
);

   // Two guard bits so sums of a score and a penalty never wrap before saturation.
   localparam int XW = WIDTH + 2;

   localparam logic signed [XW-1:0] P_MATCH      = XW'(MATCH);
   localparam logic signed [XW-1:0] P_MISMATCH   = XW'(MISMATCH);
   localparam logic signed [XW-1:0] P_GAP_OPEN   = XW'(GAP_OPEN);
   localparam logic signed [XW-1:0] P_GAP_EXTEND = XW'(GAP_EXTEND);
   localparam logic signed [XW-1:0] P_ZERO       = '0;
   localparam logic signed [XW-1:0] SAT_MAX      = XW'((1 << (WIDTH - 1)) - 1);
   localparam logic signed [XW-1:0] SAT_MIN      = XW'(-(1 << (WIDTH - 1)));

   function automatic logic signed [XW-1:0] f_ext(input logic signed [WIDTH-1:0] x);
      return {{2{x[WIDTH-1]}}, x};
   endfunction

   function automatic logic signed [XW-1:0] f_max(input logic signed [XW-1:0] a,
                                                 input logic signed [XW-1:0] b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic signed [WIDTH-1:0] f_sat(input logic signed [XW-1:0] x);
      logic signed [WIDTH-1:0] y;
      if (x > SAT_MAX)
         y = SAT_MAX[WIDTH-1:0];
      else if (x < SAT_MIN)
         y = SAT_MIN[WIDTH-1:0];
      else
         y = x[WIDTH-1:0];
      return y;
   endfunction

   logic [1:0]              r_s;
   logic signed [WIDTH-1:0] r_vd;
   logic signed [WIDTH-1:0] r_e;
   logic signed [WIDTH-1:0] r_v_out;
   logic signed [WIDTH-1:0] r_f_out;
   logic [1:0]              r_t_out;
   logic                    r_init_out;

   logic signed [XW-1:0] w_sub;
   logic signed [XW-1:0] w_diag;
   logic signed [XW-1:0] w_f_cur;
   logic signed [XW-1:0] w_e_cur;
   logic signed [XW-1:0] w_h;
   logic signed [XW-1:0] w_h_cand [4];
   logic signed [XW-1:0] w_h_run  [4];

   assign w_sub   = (r_s == T_in) ? P_MATCH : P_MISMATCH;
   assign w_diag  = f_ext(r_vd) + w_sub;
   assign w_f_cur = f_max(f_ext(V_in) + P_GAP_OPEN, f_ext(F_in) + P_GAP_EXTEND);
   assign w_e_cur = f_max(f_ext(r_v_out) + P_GAP_OPEN, f_ext(r_e) + P_GAP_EXTEND);

   // The zero candidate is the local-alignment floor.
   assign w_h_cand[0] = w_diag;
   assign w_h_cand[1] = w_e_cur;
   assign w_h_cand[2] = w_f_cur;
   assign w_h_cand[3] = P_ZERO;

   assign w_h_run[0] = w_h_cand[0];
   generate
      for (genvar gi = 1; gi < 4; gi++) begin : g_hmax
         assign w_h_run[gi] = f_max(w_h_run[gi-1], w_h_cand[gi]);
      end
   endgenerate
   assign w_h = w_h_run[3];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s        <= '0;
         r_vd       <= '0;
         r_e        <= '0;
         r_v_out    <= '0;
         r_f_out    <= '0;
         r_t_out    <= '0;
         r_init_out <= 1'b0;
      end else begin
         r_t_out    <= T_in;
         r_init_out <= init_in;
         if (store_S)
            r_s <= S_in;
         // A row boundary wipes the cell state so the next row starts fresh.
         if (init_in) begin
            r_v_out <= f_sat(w_h);
            r_f_out <= f_sat(w_f_cur);
            r_e     <= f_sat(w_e_cur);
            r_vd    <= V_in;
         end else begin
            r_v_out <= '0;
            r_f_out <= '0;
            r_e     <= '0;
            r_vd    <= '0;
         end
      end
   end

   assign V_out    = r_v_out;
   assign F_out    = r_f_out;
   assign T_out    = r_t_out;
   assign init_out = r_init_out;

endmodule

// File: tb/tb_smith_waterman_pe.sv
// Scoreboard bench for smith_waterman_pe: the driver queues hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_smith_waterman_pe;

   logic              clk = 1'b0;
   logic              rst;
   logic signed [9:0] V_in;
   logic signed [9:0] F_in;
   logic [1:0]        T_in;
   logic [1:0]        S_in;
   logic              store_S;
   logic              init_in;
   logic signed [9:0] V_out;
   logic signed [9:0] F_out;
   logic [1:0]        T_out;
   logic              init_out;

   smith_waterman_pe dut (
      .clk      (clk),
      .rst      (rst),
      .V_in     (V_in),
      .F_in     (F_in),
      .T_in     (T_in),
      .S_in     (S_in),
      .store_S  (store_S),
      .init_in  (init_in),
      .V_out    (V_out),
      .F_out    (F_out),
      .T_out    (T_out),
      .init_out (init_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      int         id;
      int         v;
      int         f;
      logic [1:0] t;
      logic       init;
   } exp_t;

   exp_t sb[$];
   int   cyc_cnt  = 0;
   int   txn_id   = 0;
   int   checks   = 0;
   int   failures = 0;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic chk(input string nm, input int id, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL txn %0d %s got %0d expected %0d", id, nm, got, want);
      end
   endtask

   exp_t m_e;
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
         m_e = sb.pop_front();
         $display("txn %0d V_out=%0d F_out=%0d T_out=%0d init_out=%0d", m_e.id,
                  int'(V_out), int'(F_out), T_out, init_out);
         chk("V_out", m_e.id, int'(V_out), m_e.v);
         chk("F_out", m_e.id, int'(F_out), m_e.f);
         chk("T_out", m_e.id, int'(T_out), int'(m_e.t));
         chk("init_out", m_e.id, int'(init_out), int'(m_e.init));
      end
   end

   task automatic step(input logic r, input logic st, input logic [1:0] s,
                       input logic ini, input logic [1:0] t, input int v, input int f,
                       input int ev, input int ef);
      exp_t x;
      @(posedge clk);
      #1;
      rst     = r;
      store_S = st;
      S_in    = s;
      init_in = ini;
      T_in    = t;
      V_in    = 10'(v);
      F_in    = 10'(f);
      x.cyc   = cyc_cnt + 1;
      x.id    = txn_id;
      x.v     = ev;
      x.f     = ef;
      x.t     = r ? 2'b00 : t;
      x.init  = r ? 1'b0 : ini;
      txn_id++;
      sb.push_back(x);
   endtask

   logic [1:0] tseq [8] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd3, 2'd0};
   int exp_a [8] = '{10, 8, 10, 8, 10, 8, 7, 10};
   int exp_c [8] = '{0, 10, 8, 7, 6, 10, 8, 7};
   int exp_t3[8] = '{8, 8, 8, 8, 8, 8, 20, 18};

   initial begin
      rst = 1'b1; store_S = 1'b0; S_in = 2'd0; init_in = 1'b0;
      T_in = 2'd0; V_in = '0; F_in = '0;

      // Reset held two cycles, then load S=A on a boundary cycle.
      step(1, 0, 2'd0, 0, 2'd0, 0, 0, 0, 0);
      step(1, 0, 2'd0, 0, 2'd0, 0, 0, 0, 0);
      step(0, 1, 2'd0, 0, 2'd0, 0, 0, 0, 0);

      for (int i = 0; i < 8; i++)
         step(0, 0, 2'd0, 1, tseq[i], 0, 0, exp_a[i], -1);

      // Boundary loading S=C, then the same reference stream.
      step(0, 1, 2'd1, 0, 2'd0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++)
         step(0, 0, 2'd1, 1, tseq[i], 0, 0, exp_c[i], -1);

      // S=T with V_in=10, F_in=-4.
      step(0, 1, 2'd3, 0, 2'd0, 10, -4, 0, 0);
      for (int i = 0; i < 8; i++)
         step(0, 0, 2'd3, 1, tseq[i], 10, -4, exp_t3[i], 8);

      // S load during a live column: the old S=A scores T=A, the new S=C scores T=C.
      step(0, 1, 2'd0, 0, 2'd0, 0, 0, 0, 0);
      step(0, 1, 2'd1, 1, 2'd0, 0, 0, 10, -1);
      step(0, 0, 2'd1, 1, 2'd1, 0, 0, 10, -1);

      // V_in at the top of range so Vd+MATCH overflows and must clamp at 511.
      step(0, 0, 2'd1, 0, 2'd1, 0, 0, 0, 0);
      step(0, 0, 2'd1, 1, 2'd1, 511, 0, 509, 509);
      step(0, 0, 2'd1, 1, 2'd1, 511, 0, 511, 509);
      step(0, 0, 2'd1, 1, 2'd1, 511, 0, 511, 509);
      // Most negative inputs push F below range: clamps at -512.
      step(0, 0, 2'd1, 1, 2'd0, -512, -512, 509, -512);

      // Reset mid-row clears everything, including S back to A.
      step(1, 0, 2'd1, 1, 2'd2, 0, 0, 0, 0);
      step(0, 0, 2'd1, 1, 2'd0, 0, 0, 10, -1);
      step(0, 0, 2'd1, 1, 2'd1, 0, 0, 8, -1);

      for (int i = 0; i < 20 && sb.size() > 0; i++) begin
         @(negedge clk);
         #1;
      end
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain pending=%0d expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
